// File: rtl/text_buf_writer.sv
// text_buf_writer: turns an ASCII byte stream into char-buffer RAM writes (cursor, CR/LF/BS/FF, wrap, row pre-clear); ports: in_valid/in_data/in_ready stream in, wr_en/wr_addr/wr_data RAM write, cur_col/cur_row cursor
module text_buf_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int ADDR_W = 12,
  parameter int COL_W = $clog2(COLS),
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [COL_W-1:0]  cur_col,
  output logic [ROW_W-1:0]  cur_row
);
  localparam int CNT_W = ADDR_W + 1;
  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_LINE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [COL_W-1:0] col_n;
  logic [ROW_W-1:0] row_n;
  logic [ADDR_W-1:0] addr_n, row_base;
  logic [7:0] data_n;
  logic we_n, rdy_n, adv, printable, eol, last_row;
  assign row_base = ADDR_W'(cur_row) * ADDR_W'(COLS);
  assign printable = in_data >= 8'h20 && in_data <= 8'h7e;
  assign eol = cur_col == COL_W'(COLS - 1);
  assign last_row = cur_row == ROW_W'(ROWS - 1);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    col_n = cur_col;
    row_n = cur_row;
    addr_n = wr_addr;
    data_n = wr_data;
    we_n = 1'b0;
    rdy_n = in_ready;
    adv = 1'b0;
    case (state)
      CLR_ALL:
        if (cnt == CNT_W'(COLS * ROWS)) begin
          state_n = IDLE;
          rdy_n = 1'b1;
          cnt_n = '0;
        end else begin
          we_n = 1'b1;
          addr_n = ADDR_W'(cnt);
          data_n = 8'h20;
          cnt_n = cnt + CNT_W'(1);
        end
      CLR_LINE:
        if (cnt == CNT_W'(COLS)) begin
          state_n = IDLE;
          rdy_n = 1'b1;
          cnt_n = '0;
        end else begin
          we_n = 1'b1;
          addr_n = row_base + ADDR_W'(cnt);
          data_n = 8'h20;
          cnt_n = cnt + CNT_W'(1);
        end
      IDLE:
        if (in_valid) begin
          if (printable) begin
            we_n = 1'b1;
            addr_n = row_base + ADDR_W'(cur_col);
            data_n = in_data;
            col_n = eol ? '0 : cur_col + COL_W'(1);
            adv = eol;
          end else if (in_data == 8'h0d) begin
            col_n = '0;
          end else if (in_data == 8'h0a) begin
            col_n = '0;
            adv = 1'b1;
          end else if (in_data == 8'h08 && cur_col != '0) begin
            col_n = cur_col - COL_W'(1);
            we_n = 1'b1;
            addr_n = row_base + ADDR_W'(cur_col) - ADDR_W'(1);
            data_n = 8'h20;
          end else if (in_data == 8'h0c) begin
            col_n = '0;
            row_n = '0;
            state_n = CLR_ALL;
            rdy_n = 1'b0;
          end
          if (adv) begin
            row_n = last_row ? '0 : cur_row + ROW_W'(1);
            state_n = CLR_LINE;
            rdy_n = 1'b0;
          end
        end
      default: begin
        state_n = CLR_ALL;
        cnt_n = '0;
        rdy_n = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLR_ALL;
      cnt <= '0;
      cur_col <= '0;
      cur_row <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'h20;
      in_ready <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cur_col <= col_n;
      cur_row <= row_n;
      wr_en <= we_n;
      wr_addr <= addr_n;
      wr_data <= data_n;
      in_ready <= rdy_n;
    end
endmodule

// File: tb/tb_text_buf_writer.sv
// tb_text_buf_writer: randomized and directed checks of text_buf_writer against a screen/cursor reference model
module tb_text_buf_writer;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int ADDR_W = 12;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int N = COLS * ROWS;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0] wr_data;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;
  int n_tests = 0;
  int n_fail = 0;
  int mcol = 0;
  int mrow = 0;
  logic [7:0] scr[N];
  logic [7:0] dut_scr[1 << ADDR_W];
  logic [ADDR_W+7:0] expq[$];
  text_buf_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cur_col(cur_col), .cur_row(cur_row)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_cur(input string tag, input int r, input int c);
    check(tag, {cur_row, cur_col}, {ROW_W'(r), COL_W'(c)});
  endtask
  task automatic push(input int a, input logic [7:0] d);
    expq.push_back({ADDR_W'(a), d});
    scr[a] = d;
  endtask
  task automatic advance();
    mrow = (mrow + 1) % ROWS;
    for (int c = 0; c < COLS; c++) push(mrow * COLS + c, 8'h20);
  endtask
  task automatic model(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7e) begin
      push(mrow * COLS + mcol, b);
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        advance();
      end
    end else if (b == 8'h0d) mcol = 0;
    else if (b == 8'h0a) begin
      mcol = 0;
      advance();
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        push(mrow * COLS + mcol, 8'h20);
      end
    end else if (b == 8'h0c) begin
      mcol = 0;
      mrow = 0;
      for (int k = 0; k < N; k++) push(k, 8'h20);
    end
  endtask
  always @(negedge clk)
    if (wr_en === 1'b1) begin
      dut_scr[wr_addr] = wr_data;
      if (expq.size() == 0) check("wr_extra", 64'd1, 64'd0);
      else check("wr", {wr_addr, wr_data}, expq.pop_front());
    end
  task automatic send(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data = b;
    while (in_ready !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) check("ready_timeout", {63'd0, in_ready}, 64'd1);
    model(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic type_n(input int n);
    repeat (n) send(8'($urandom_range(32, 126)));
  endtask
  task automatic wait_clear(input int n, input string tag);
    int c = 0;
    repeat (n) begin
      @(negedge clk);
      if (wr_en && !in_ready) c++;
    end
    check({tag, "_len"}, c, n);
    @(negedge clk);
    check({tag, "_done"}, {in_ready, wr_en}, 2'b10);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_vals", {wr_en, wr_addr, wr_data, in_ready, cur_row, cur_col},
          {1'b0, ADDR_W'(0), 8'h20, 1'b0, ROW_W'(0), COL_W'(0)});
    @(negedge clk);
    expq.delete();
    mcol = 0;
    mrow = 0;
    for (int k = 0; k < N; k++) push(k, 8'h20);
    check("rst_hold", {wr_en, in_ready}, 2'b00);
    rst = 1'b0;
    wait_clear(N, "clr_all");
    chk_cur("init_cur", 0, 0);
  endtask
  function automatic logic [7:0] rnd_byte();
    int r = $urandom_range(0, 99);
    if (r < 70) return 8'($urandom_range(32, 126));
    if (r < 75) return 8'h0a;
    if (r < 80) return 8'h0d;
    if (r < 89) return 8'h08;
    if (r < 90) return 8'h0c;
    return 8'($urandom_range(0, 255));
  endfunction
  initial begin
    int t, mism;
    @(negedge clk);
    do_reset();
    send(8'h41);
    check("A_wr", {wr_en, wr_addr, wr_data}, {1'b1, ADDR_W'(0), 8'h41});
    check("A_rdy", {63'd0, in_ready}, 64'd1);
    send(8'h42);
    check("B_wr", {wr_en, wr_addr, wr_data}, {1'b1, ADDR_W'(1), 8'h42});
    chk_cur("AB_cur", 0, 2);
    send(8'h0d);
    chk_cur("cr_cur", 0, 0);
    repeat (3) begin
      send(8'h0a);
      wait_clear(COLS, "lf");
    end
    type_n(COLS - 1);
    chk_cur("pre_eol_cur", 3, COLS - 1);
    send(8'h5a);
    check("eol_wr", {wr_en, wr_addr, wr_data, in_ready}, {1'b1, ADDR_W'(319), 8'h5a, 1'b0});
    chk_cur("eol_cur", 4, 0);
    wait_clear(COLS, "eol_clr");
    repeat (25) begin
      send(8'h0a);
      wait_clear(COLS, "lf");
    end
    type_n(10);
    chk_cur("pre_wrap_cur", 29, 10);
    send(8'h0a);
    chk_cur("wrap_cur", 0, 0);
    wait_clear(COLS, "wrap_clr");
    repeat (2) begin
      send(8'h0a);
      wait_clear(COLS, "lf");
    end
    type_n(5);
    send(8'h08);
    check("bs_wr", {wr_en, wr_addr, wr_data}, {1'b1, ADDR_W'(164), 8'h20});
    chk_cur("bs_cur", 2, 4);
    send(8'h0d);
    send(8'h08);
    check("bs0_nowr", {63'd0, wr_en}, 64'd0);
    chk_cur("bs0_cur", 2, 0);
    send(8'h07);
    check("bel_nowr", {wr_en, in_ready}, 2'b01);
    chk_cur("bel_cur", 2, 0);
    type_n(7);
    send(8'h0c);
    check("ff_start", {wr_en, in_ready}, 2'b00);
    chk_cur("ff_cur", 0, 0);
    wait_clear(N, "ff_clr");
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(rnd_byte());
      chk_cur("rnd_cur", mrow, mcol);
    end
    send(8'h0a);
    repeat (20) @(negedge clk);
    #2;
    do_reset();
    type_n(12);
    send(8'h0a);
    type_n(3);
    t = 0;
    while (in_ready !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("expq_empty", expq.size(), 0);
    mism = 0;
    for (int k = 0; k < N; k++) if (dut_scr[k] !== scr[k]) mism++;
    check("screen", mism, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/text_buf_writer.md
Name: text_buf_writer

Overview:
- Write-side front end of the text-mode display: accepts a stream of ASCII bytes and turns them into writes to the dual-port character buffer RAM.
- The character ROM controller path reads that RAM on the scan-out side.
- Maintains a cursor; handles CR, LF, BS and FF; auto-wraps at end of line.
- Clears each new row before it is used, so the screen wraps top-to-bottom without needing a read-back scroll.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows per screen
- ADDR_W, 12, buffer address width; must satisfy 2^ADDR_W >= COLS*ROWS
- COL_W, $clog2(COLS), cursor column width (7 at default)
- ROW_W, $clog2(ROWS), cursor row width (5 at default)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  byte offered on in_data
- in_data  in  8  ASCII byte
- in_ready  out  1  block can accept; byte consumed when in_valid && in_ready at a clk edge
- wr_en  out  1  buffer RAM write strobe
- wr_addr  out  ADDR_W  buffer address = row*COLS + col
- wr_data  out  8  character to write
- cur_col  out  COL_W  cursor column, 0..COLS-1
- cur_row  out  ROW_W  cursor row, 0..ROWS-1

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- All outputs are registered.
- Reset values: wr_en=0, wr_addr=0, wr_data=0x20, cur_col=0, cur_row=0, in_ready=0, state=CLR_ALL, clear counter=0.
- State CLR_ALL:
  - On each cycle, write 0x20 to address k, for k=0..COLS*ROWS-1; wr_en=1 for exactly COLS*ROWS consecutive cycles.
  - in_ready=0 throughout.
  - After the last write, go to IDLE with the cursor at (0,0).
  - The first write appears on the first edge after rst deasserts.
- State IDLE:
  - in_ready=1.
  - On accept at edge N, the effects (write, cursor update) are visible after edge N, i.e. one cycle of latency.
  - in_ready drops in the same cycle the state leaves IDLE.
  - Back-to-back accepts of printable bytes are allowed: one write per cycle.
- Byte decode on accept:
  - 0x20..0x7E printable:
    - Write the byte at (cur_col, cur_row); cur_col+1.
    - If cur_col was COLS-1: cur_col=0 and perform the row advance.
  - 0x0D CR: cur_col=0; no write.
  - 0x0A LF: cur_col=0; perform the row advance.
  - 0x08 BS:
    - If cur_col>0: cur_col-1, and write 0x20 at the new position.
    - If cur_col=0: no-op (no row change, no write).
  - 0x0C FF: cursor to (0,0); enter CLR_ALL.
  - All other bytes (0x00..0x1F except those above, and 0x7F..0xFF): accepted, ignored, no write.
- Row advance:
  - cur_row+1, wrapping from ROWS-1 to 0.
  - Enter CLR_LINE for the new row.
- State CLR_LINE:
  - Write 0x20 to row*COLS + c, for c=0..COLS-1: COLS cycles with wr_en=1, in_ready=0.
  - Then return to IDLE.
  - For a printable at the last column, the character write occurs first (cycle N+1) and the CLR_LINE writes follow from cycle N+2.
- Outside write cycles: wr_en=0; wr_addr and wr_data hold their last value.
- in_valid while in_ready=0: ignored; no byte is lost as long as the producer holds it.
- rst asserted mid-CLR_LINE or mid-stream: immediate return to reset values; the full CLR_ALL restarts after deassert.
- Address arithmetic: computed at full ADDR_W width, no truncation; wr_addr never exceeds COLS*ROWS-1.

Test Plan:
- Reset, then deassert -> wr_en high for exactly 2400 cycles, addresses 0..2399, data 0x20; in_ready rises on the cycle after; cursor (0,0).
- After init, send "A"(0x41),"B" back-to-back -> writes (addr 0, 0x41), (addr 1, 0x42) on consecutive cycles; cur_col=2.
- Cursor at (79,3), send 0x5A -> write addr 319 = 0x5A; then 80 writes of 0x20 at addr 320..399; in_ready low for those 80 cycles; cursor (0,4).
- Cursor at (10,29), send LF -> clears addr 0..79; cursor (0,0).
- Cursor (5,2), send BS -> write 0x20 at addr 164, cursor (4,2). At (0,2), send BS -> no write, cursor unchanged. Send 0x07 -> accepted, no write.
- FF mid-screen -> 2400-cycle clear, cursor (0,0). Separately, assert rst during a CLR_LINE -> outputs at reset values; full clear restarts.
